imem_loader: RTL and testbench

//   Boot-time program loader: the write side of the instruction RAM that the core only reads.
//   - Receives a framed byte stream (e.g. from a UART RX) and assembles little-endian 32-bit words.
//   - Writes each word into instruction RAM at consecutive word addresses.
//   - Holds the core in reset until a frame with a valid checksum has been fully written.

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write side of the boot loader,
// plus the status lines the rest of the SoC watches.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;
    logic        busy;

    // Byte source / status observer
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, busy
    );

    // Loader
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, busy
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream (SYNC, LEN, data,
// CSUM), writes little-endian words into instruction RAM at consecutive word
// addresses and releases the core from reset once a frame checks out.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned TIMEOUT     = 100000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [31:0]        len;
    logic [31:0]        word_idx;
    logic [23:0]        word_buf;
    logic [7:0]         sum;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               xfer;
    logic [31:0]        len_next;

    // Transfer qualifier and the length word as it stands with the current byte shifted in
    always_comb begin
        xfer     = bus.in_valid & bus.in_ready;
        len_next = {bus.in_data, len[31:8]};
    end

    // Frame parser, RAM write strobe and all status outputs, registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_SYNC;
            byte_cnt      <= '0;
            len           <= '0;
            word_idx      <= '0;
            word_buf      <= '0;
            sum           <= '0;
            idle_cnt      <= '0;
            bus.in_ready  <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            bus.core_rst  <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if (xfer) begin
                idle_cnt <= '0;
            end

            case (state)
                S_SYNC: begin
                    if (xfer && bus.in_data == SYNC_BYTE) begin
                        state    <= S_LEN;
                        bus.err  <= 1'b0;
                        bus.busy <= 1'b1;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        sum      <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next > DEPTH_WORDS) begin
                                state        <= S_ERR;
                                bus.in_ready <= 1'b0;
                                bus.busy     <= 1'b0;
                            end else if (len_next == '0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum      <= sum + bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {bus.in_data, word_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= {bus.in_data, word_buf};
                            bus.mem_addr  <= BASE_ADDR + (word_idx << 2);
                            word_idx      <= word_idx + 32'd1;
                            if (word_idx == len - 32'd1) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        state        <= (bus.in_data == sum) ? S_DONE : S_ERR;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                        if (bus.in_data == sum) begin
                            bus.done     <= 1'b1;
                            bus.core_rst <= 1'b0;
                        end
                    end
                end
                S_ERR: begin
                    bus.err      <= 1'b1;
                    bus.in_ready <= 1'b1;
                    state        <= S_SYNC;
                end
                S_DONE: begin
                end
                default: begin
                    state <= S_SYNC;
                end
            endcase

            // Idle watchdog inside a frame; overrides the case above only on non-transfer cycles
            if ((state == S_LEN || state == S_DATA || state == S_CSUM) && !xfer) begin
                if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    state        <= S_ERR;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model (expected writes with
// their cycle stamps, status intervals) checked every cycle, directed boundary
// scenarios plus randomized frames.
module tb_imem_loader;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if bus();

    imem_loader #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .TIMEOUT    (TMO),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    // Reference model state
    wr_t         exp_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  payload[$];
    logic        exp_busy, exp_done, exp_err;
    logic [31:0] exp_addr;
    int          err_at, busy_off_at;
    bit          chk_en = 1'b0;
    logic [7:0]  last_sum;

    task automatic model_reset();
        exp_q.delete();
        log_addr.delete();
        log_data.delete();
        exp_busy    = 1'b0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_addr    = BASE;
        err_at      = -10;
        busy_off_at = -10;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (cyc == err_at) exp_err = 1'b1;
            if (cyc == busy_off_at) exp_busy = 1'b0;
            chk("in_ready", bus.in_ready, 32'(!exp_done && cyc != err_at - 1));
            chk("busy", bus.busy, 32'(exp_busy));
            chk("done", bus.done, 32'(exp_done));
            chk("core_rst", bus.core_rst, 32'(!exp_done));
            chk("err", bus.err, 32'(exp_err));
            if (bus.mem_we) begin
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_wdata);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("mem_we", bus.mem_we, 1);
                chk("mem_addr", bus.mem_addr, exp_q[0].addr);
                chk("mem_wdata", bus.mem_wdata, exp_q[0].data);
                exp_addr = exp_q[0].addr;
                void'(exp_q.pop_front());
            end else begin
                chk("mem_we_idle", bus.mem_we, 0);
                chk("mem_addr_hold", bus.mem_addr, exp_addr);
            end
        end
    end

    // Present one byte after `gap` idle cycles; returns the cycle of the accepting edge
    task automatic send_byte(input logic [7:0] b, input int unsigned gap, output int acc);
        bit rdy;
        int tries;
        @(negedge clk);
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        acc   = -1;
        tries = 0;
        while (acc < 0) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = cyc;
            end else begin
                tries++;
                if (tries > 50) begin
                    n_chk++;
                    $display("FAIL accept_wait: in_ready stayed 0 for %0d cycles, expected acceptance", tries);
                    $display("%0d/%0d checks passed", n_pass, n_chk);
                    $fatal(1, "byte never accepted");
                end
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic int unsigned rgap(input int unsigned maxgap);
        if (maxgap == 0) return 0;
        if ($urandom_range(15, 0) == 0) return TMO - 1;
        return $urandom_range(maxgap, 0);
    endfunction

    // Whole frame; data bytes come from `payload` when queued, else random.
    // A nonzero delta corrupts the checksum byte.
    task automatic send_frame(input logic [31:0] len, input logic [7:0] delta,
                              input int unsigned maxgap, input int unsigned sync_gap);
        int          acc;
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [31:0] w;
        wr_t         e;
        send_byte(8'hA5, sync_gap, acc);
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = len[8*k +: 8];
            send_byte(b, rgap(maxgap), acc);
        end
        if (len > DEPTH) begin
            exp_busy = 1'b0;
            err_at   = acc + 1;
            repeat (3) @(negedge clk);
            return;
        end
        sum = '0;
        w   = '0;
        for (int unsigned i = 0; i < len; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (payload.size() > 0) b = payload.pop_front();
                else b = 8'($urandom);
                sum = sum + b;
                w[8*k +: 8] = b;
                send_byte(b, rgap(maxgap), acc);
                if (k == 3) begin
                    e.cyc  = acc;
                    e.addr = BASE + 32'(4 * i);
                    e.data = w;
                    exp_q.push_back(e);
                end
            end
        end
        last_sum = sum;
        b = sum + delta;
        send_byte(b, rgap(maxgap), acc);
        exp_busy = 1'b0;
        if (delta == 8'h00) exp_done = 1'b1;
        else err_at = acc + 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_example();
        logic [7:0] ex [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) payload.push_back(ex[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, BASE);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_core_rst"}, bus.core_rst, 1);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        wr_t e;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        // Leading garbage, a long pause in SYNC, then the example frame
        send_byte(8'h00, 0, acc);
        send_byte(8'hFF, 0, acc);
        send_byte(8'h5A, 0, acc);
        chk("garbage_no_write", log_addr.size(), 0);
        load_example();
        send_frame(2, 8'h00, 0, 2 * TMO);
        chk("ex_model_sum", last_sum, 8'hB6);
        chk("ex_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("ex_w0_addr", log_addr[0], 32'h0000_0000);
            chk("ex_w0_data", log_data[0], 32'h0000_0013);
            chk("ex_w1_addr", log_addr[1], 32'h0000_0004);
            chk("ex_w1_data", log_data[1], 32'h0010_0093);
        end
        chk("ex_done", bus.done, 1);
        chk("ex_core_rst", bus.core_rst, 0);
        chk("ex_in_ready", bus.in_ready, 0);

        // Bad checksum (B7), then a good frame rewriting from BASE
        apply_reset();
        load_example();
        send_frame(2, 8'h01, 0, 0);
        chk("badsum_err", bus.err, 1);
        chk("badsum_done", bus.done, 0);
        chk("badsum_core_rst", bus.core_rst, 1);
        load_example();
        send_frame(2, 8'h00, 1, 0);
        chk("badsum_retry_err", bus.err, 0);
        chk("badsum_retry_done", bus.done, 1);
        chk("badsum_nwrites", log_addr.size(), 4);
        if (log_addr.size() == 4) chk("badsum_retry_addr", log_addr[2], BASE);

        // Oversize length, then an empty frame
        apply_reset();
        send_frame(DEPTH + 1, 8'h00, 0, 0);
        chk("oversize_err", bus.err, 1);
        chk("oversize_nwrites", log_addr.size(), 0);
        send_frame(0, 8'h00, 0, 0);
        chk("empty_done", bus.done, 1);
        chk("empty_nwrites", log_addr.size(), 0);

        // Timeout: TMO-1 idle cycles tolerated, TMO idle cycles mid-word abort
        apply_reset();
        send_byte(8'hA5, 0, acc);
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        send_byte(8'h02, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h11, 0, acc);
        send_byte(8'h22, TMO - 1, acc);
        send_byte(8'h33, 0, acc);
        send_byte(8'h44, 0, acc);
        e.cyc  = acc;
        e.addr = BASE;
        e.data = 32'h4433_2211;
        exp_q.push_back(e);
        send_byte(8'h55, TMO - 1, acc);
        send_byte(8'h66, 0, acc);
        busy_off_at = acc + TMO;
        err_at      = acc + TMO + 1;
        repeat (TMO + 4) @(negedge clk);
        chk("tmo_err", bus.err, 1);
        chk("tmo_done", bus.done, 0);
        chk("tmo_core_rst", bus.core_rst, 1);
        chk("tmo_nwrites", log_addr.size(), 1);
        load_example();
        send_frame(2, 8'h00, 0, 0);
        chk("tmo_retry_done", bus.done, 1);

        // Reset after 6 data bytes, then a clean load from BASE
        apply_reset();
        send_byte(8'hA5, 0, acc);
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        send_byte(8'h04, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h00, 0, acc);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hC0 + 8'(i), 0, acc);
            if (i == 3) begin
                e.cyc  = acc;
                e.addr = BASE;
                e.data = 32'hC3C2_C1C0;
                exp_q.push_back(e);
            end
        end
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        load_example();
        send_frame(2, 8'h00, 0, 0);
        chk("midrst_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) chk("midrst_first_addr", log_addr[0], BASE);
        chk("midrst_done", bus.done, 1);

        // Randomized sessions: garbage, a few failing frames, then a good one
        for (int it = 0; it < 6; it++) begin
            int nbad;
            logic [7:0] g;
            apply_reset();
            for (int j = 0; j < int'($urandom_range(4, 0)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(3, 0), acc);
            end
            nbad = int'($urandom_range(2, 0));
            for (int j = 0; j < nbad; j++) begin
                if ($urandom_range(1, 0) == 0)
                    send_frame(DEPTH + 1 + $urandom_range(500, 0), 8'h00, 2, 0);
                else
                    send_frame($urandom_range(DEPTH, 0), 8'($urandom_range(255, 1)), 2, 0);
                chk("rand_bad_err", bus.err, 1);
            end
            send_frame($urandom_range(DEPTH, 0), 8'h00, 2, $urandom_range(3, 0));
            chk("rand_good_done", bus.done, 1);
            chk("rand_good_err", bus.err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
